pipe_skid_stage: RTL and testbench

Parametrised pipeline-stage register for the RISC-V pipeline. It generalises the fixed 32+32-bit stall/flush stage register to any payload width and uses a valid/ready handshake. An optional 2-entry skid buffer registers the upstream ready, so stalls never form a combinational path back through the pipeline. It is instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB, and exports saturating stall and flush counters for performance analysis.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/sat_counter.sv | 36 +++
 rtl/pipe_skid_stage.sv | 136 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and constants for pipeline stage registers
package pipe_pkg;

    // Stage occupancy state; the fourth encoding is illegal and recovers to ST_EMPTY
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKIDF = 2'd2
    } stage_state_e;

    // RISC-V canonical NOP (addi x0, x0, 0), used as the flush payload of ID/EX
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    // Number of held entries for a given state
    function automatic logic [1:0] occ_of(stage_state_e s);
        case (s)
            ST_FULL:  return 2'd1;
            ST_SKIDF: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter for stage performance monitoring
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Increment on a qualifying cycle, stick at the all-ones value
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end
    end

    // Counter register, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - valid/ready pipeline stage register with optional 2-entry skid buffer
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned          DATA_W    = 64,
    parameter bit                   SKID      = 1'b1,
    parameter logic [DATA_W-1:0]    FLUSH_VAL = '0,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    stage_state_e      state_q;
    stage_state_e      state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              up_xfer;
    logic              dn_xfer;

    assign out_valid = (state_q == ST_FULL) || (state_q == ST_SKIDF);
    assign out_data  = main_q;
    assign occupancy = occ_of(state_q);
    assign up_xfer   = in_valid && in_ready;
    assign dn_xfer   = out_valid && out_ready;

    // Skid mode decodes ready from the state register alone, cutting the
    // combinational stall path; the plain register passes out_ready through.
    generate
        if (SKID) begin : g_ready_reg
            assign in_ready = (state_q != ST_SKIDF);
        end else begin : g_ready_comb
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    // Next-state and payload steering; flush outranks every transfer
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = FLUSH_VAL;
            skid_d  = FLUSH_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (up_xfer) begin
                        state_d = ST_FULL;
                        main_d  = in_data;
                    end
                end
                ST_FULL: begin
                    if (dn_xfer && up_xfer) begin
                        main_d = in_data;
                    end else if (dn_xfer) begin
                        state_d = ST_EMPTY;
                    end else if (up_xfer && SKID) begin
                        // Downstream stalled: park the new payload behind main
                        state_d = ST_SKIDF;
                        skid_d  = in_data;
                    end
                end
                ST_SKIDF: begin
                    if (!SKID) begin
                        state_d = ST_EMPTY;
                    end else if (dn_xfer) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and main payload register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= FLUSH_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    generate
        if (SKID) begin : g_skid
            // Skid entry register, only present in skid mode
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skid_q <= FLUSH_VAL;
                end else begin
                    skid_q <= skid_d;
                end
            end
        end else begin : g_no_skid
            assign skid_q = FLUSH_VAL;
        end
    endgenerate

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - self-checking bench for pipe_skid_stage
module tb_pipe_skid_stage;

    localparam int W = 64;
    localparam logic [W-1:0] NOP64 = 64'h13;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_data;

    logic         ir  [3];
    logic         ov  [3];
    logic [W-1:0] od  [3];
    logic [1:0]   occ [3];
    logic [15:0]  sc0, fc0, sc1, fc1;
    logic [3:0]   sc2, fc2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each stage is an ordered list of up to two payloads
    logic [W-1:0] ent  [3][2];
    int           cnt  [3];
    logic [W-1:0] hold [3];
    int           msc  [3];
    int           mfc  [3];
    int           cmax [3] = '{65535, 65535, 15};
    bit           skid [3] = '{1'b1, 1'b0, 1'b1};
    logic [W-1:0] fv   [3];

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(W), .SKID(1'b1), .FLUSH_VAL(64'h0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .occupancy(occ[0]), .stall_cnt(sc0), .flush_cnt(fc0));

    pipe_skid_stage #(.DATA_W(W), .SKID(1'b0), .FLUSH_VAL(64'h0), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .occupancy(occ[1]), .stall_cnt(sc1), .flush_cnt(fc1));

    pipe_skid_stage #(.DATA_W(W), .SKID(1'b1), .FLUSH_VAL(NOP64), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
        .occupancy(occ[2]), .stall_cnt(sc2), .flush_cnt(fc2));

    function automatic logic [63:0] sc_of(int k);
        case (k)
            0:       return 64'(sc0);
            1:       return 64'(sc1);
            default: return 64'(sc2);
        endcase
    endfunction

    function automatic logic [63:0] fc_of(int k);
        case (k)
            0:       return 64'(fc0);
            1:       return 64'(fc1);
            default: return 64'(fc2);
        endcase
    endfunction

    function automatic bit m_ready(int k);
        if (skid[k]) return cnt[k] < 2;
        return (cnt[k] == 0) || out_ready;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            cnt[k]  = 0;
            hold[k] = fv[k];
            msc[k]  = 0;
            mfc[k]  = 0;
        end
    endtask

    // Advance the model by one clock using the inputs seen at the edge
    task automatic m_step();
        for (int k = 0; k < 3; k++) begin
            bit up;
            bit dn;
            up = in_valid && m_ready(k);
            dn = (cnt[k] > 0) && out_ready;
            if ((cnt[k] > 0) && !out_ready && (msc[k] < cmax[k])) msc[k]++;
            if (flush && (mfc[k] < cmax[k])) mfc[k]++;
            if (flush) begin
                cnt[k]  = 0;
                hold[k] = fv[k];
            end else begin
                if (dn) begin
                    ent[k][0] = ent[k][1];
                    cnt[k]--;
                end
                if (up) begin
                    ent[k][cnt[k]] = in_data;
                    cnt[k]++;
                end
                if (cnt[k] > 0) hold[k] = ent[k][0];
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("d%0d.out_valid", k), 64'(ov[k]), 64'(cnt[k] > 0));
            chk($sformatf("d%0d.out_data", k), od[k], hold[k]);
            chk($sformatf("d%0d.in_ready", k), 64'(ir[k]), 64'(m_ready(k)));
            chk($sformatf("d%0d.occupancy", k), 64'(occ[k]), 64'(cnt[k]));
            chk($sformatf("d%0d.stall_cnt", k), sc_of(k), 64'(msc[k]));
            chk($sformatf("d%0d.flush_cnt", k), fc_of(k), 64'(mfc[k]));
        end
    endtask

    // Drive one cycle of inputs, compare against the model, then clock both
    task automatic step(bit iv, logic [63:0] d, bit ordy, bit fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_all();
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    initial begin
        fv[0] = 64'h0;
        fv[1] = 64'h0;
        fv[2] = NOP64;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        m_reset();
        #12;
        chk("reset.out_valid", 64'(ov[0]), 64'h0);
        chk("reset.out_data", od[0], 64'h0);
        chk("reset.out_data_nop", od[2], 64'h13);
        chk("reset.in_ready", 64'(ir[0]), 64'h1);
        chk("reset.occupancy", 64'(occ[0]), 64'h0);
        chk("reset.stall_cnt", 64'(sc0), 64'h0);
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back stream with downstream always ready
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 64'(i), 1'b1, 1'b0);
            chk("b2b.out_data", od[0], 64'(i));
            chk("b2b.out_valid", 64'(ov[0]), 64'h1);
        end
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("b2b.stall_cnt", 64'(sc0), 64'h0);

        // Skid fill and drain
        step(1'b1, 64'hA, 1'b0, 1'b0);
        chk("skid.occ1", 64'(occ[0]), 64'h1);
        step(1'b1, 64'hB, 1'b0, 1'b0);
        chk("skid.occ2", 64'(occ[0]), 64'h2);
        chk("skid.in_ready", 64'(ir[0]), 64'h0);
        step(1'b0, 64'h0, 1'b0, 1'b0);
        chk("skid.stall_cnt", 64'(sc0), 64'h2);
        chk("skid.head", od[0], 64'hA);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("skid.second", od[0], 64'hB);
        chk("skid.drain1", 64'(occ[0]), 64'h1);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("skid.drain0", 64'(occ[0]), 64'h0);

        // Flush while two entries are held, with a same-cycle input
        step(1'b1, 64'hD, 1'b0, 1'b0);
        step(1'b1, 64'hE, 1'b0, 1'b0);
        chk("flush.pre_occ", 64'(occ[0]), 64'h2);
        step(1'b1, 64'hC, 1'b0, 1'b1);
        chk("flush.out_valid", 64'(ov[0]), 64'h0);
        chk("flush.occupancy", 64'(occ[0]), 64'h0);
        chk("flush.flush_cnt", 64'(fc0), 64'h1);
        chk("flush.out_data", od[0], 64'h0);
        chk("flush.out_data_nop", od[2], 64'h13);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("flush.no_0xC", 64'(ov[0]), 64'h0);

        // Combinational ready of the plain register follows out_ready
        step(1'b1, 64'h21, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bit ordy;
            ordy      = 1'(i % 2);
            in_valid  = 1'b1;
            out_ready = ordy;
            #1;
            chk("noskid.ready_follows", 64'(ir[1]), 64'(ordy));
            chk("noskid.occ_max", 64'(occ[1] > 2'd1), 64'h0);
            step(1'b1, 64'h30 + 64'(i), ordy, 1'b0);
        end

        // Long stall saturates the 4-bit counter
        step(1'b1, 64'h40, 1'b0, 1'b0);
        repeat (20) step(1'b0, 64'h0, 1'b0, 1'b0);
        chk("sat.stall_cnt", 64'(sc2), 64'hF);
        step(1'b0, 64'h0, 1'b0, 1'b0);
        chk("sat.hold", 64'(sc2), 64'hF);

        // Asynchronous reset in the middle of a stream
        repeat (3) step(1'b1, 64'h50, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.out_valid", 64'(ov[0]), 64'h0);
        chk("arst.out_data", od[0], 64'h0);
        chk("arst.out_data_nop", od[2], 64'h13);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        chk("arst.in_ready", 64'(ir[0]), 64'h1);
        chk("arst.occupancy", 64'(occ[0]), 64'h0);

        // Randomised traffic against the model
        repeat (600) begin
            step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        step(1'b0, 64'h0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
